sram_ctrl: RTL and testbench

Sequencer and two-port arbiter for the 16-bit asynchronous-style data SRAM (20-bit halfword address, active-low WE/CE/OE/LB/UB, shared bidirectional data bus). It gives the 32-bit core two request ports: an instruction-fetch port (read-only) and a load/store port (read/write with byte enables). It grants one port at a time and splits each 32-bit access into two 16-bit SRAM phases. It sits between the core's fetch/LSU stages and the memory macro, and is the only driver of the SRAM control pins.

---
 rtl/sram_ctrl_if.sv | 25 ++
 rtl/sram_ctrl.sv | 151 +++++++++++++++
 tb/tb_sram_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_if.sv
// Core-side request/response bundle for sram_ctrl: fetch port (i_*) and load/store port (d_*).
// Requests are held by the core until the matching one-cycle ready pulse.
interface sram_ctrl_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;

    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
        input  i_rdata, i_ready, d_rdata, d_ready
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
        output i_rdata, i_ready, d_rdata, d_ready
    );
endinterface

// File: rtl/sram_ctrl.sv
// Round-robin fetch/LSU arbiter splitting each 32-bit access into two 16-bit SRAM phases; ready 3 cycles
// after grant (fewer for partial stores), one access per 4 cycles; the losing port simply waits with req held.
module sram_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    sram_ctrl_if.slave  core,
    output logic [19:0] sram_a,
    inout  wire  [15:0] sram_dq,
    output logic        sram_we_n,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_lb_n,
    output logic        sram_ub_n
);
    typedef enum logic [1:0] {IDLE, PH0, PH1, DONE} state_t;

    typedef struct packed {
        logic [19:0] a;
        logic [15:0] dq;
        logic        ce_n;
        logic        we_n;
        logic        oe_n;
        logic        ub_n;
        logic        lb_n;
    } bus_t;

    localparam bus_t BUS_IDLE = '{a: 20'd0, dq: 16'd0, ce_n: 1'b1, we_n: 1'b1,
                                  oe_n: 1'b1, ub_n: 1'b1, lb_n: 1'b1};

    // ph=0 is the upper halfword (even address), ph=1 the lower (odd address).
    function automatic bus_t phase_bus(input logic ph, input logic we, input logic [3:0] be,
                                       input logic [18:0] wa, input logic [31:0] wd);
        bus_t b;
        b.a    = {wa, ph};
        b.dq   = ph ? wd[15:0] : wd[31:16];
        b.ce_n = 1'b0;
        b.we_n = ~we;
        b.oe_n = we;
        b.ub_n = we & ~(ph ? be[1] : be[3]);
        b.lb_n = we & ~(ph ? be[0] : be[2]);
        return b;
    endfunction

    state_t      state;
    bus_t        ctl;
    logic        gnt_d;
    logic        last_d;
    logic        lat_we;
    logic [3:0]  lat_be;
    logic [18:0] lat_wa;
    logic [31:0] lat_wd;

    logic        sel_d;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [18:0] sel_wa;

    always_comb begin
        sel_d  = core.d_req & (~core.i_req | ~last_d);
        sel_we = sel_d & core.d_we;
        sel_be = sel_d ? core.d_be : 4'hF;
        sel_wa = sel_d ? core.d_addr[20:2] : core.i_addr[20:2];
    end

    logic unused_addr;
    assign unused_addr = ^{core.i_addr[31:21], core.i_addr[1:0], core.d_addr[31:21], core.d_addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ctl          <= BUS_IDLE;
            gnt_d        <= 1'b0;
            last_d       <= 1'b0;
            lat_we       <= 1'b0;
            lat_be       <= 4'h0;
            lat_wa       <= 19'd0;
            lat_wd       <= 32'd0;
            core.i_ready <= 1'b0;
            core.d_ready <= 1'b0;
            core.i_rdata <= 32'd0;
            core.d_rdata <= 32'd0;
        end else begin
            core.i_ready <= 1'b0;
            core.d_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (core.i_req || core.d_req) begin
                        gnt_d  <= sel_d;
                        last_d <= sel_d;
                        lat_we <= sel_we;
                        lat_be <= sel_be;
                        lat_wa <= sel_wa;
                        lat_wd <= core.d_wdata;
                        // Store halves with no enabled bytes cost no SRAM cycle at all.
                        if (!sel_we || sel_be[3:2] != 2'b00) begin
                            state <= PH0;
                            ctl   <= phase_bus(1'b0, sel_we, sel_be, sel_wa, core.d_wdata);
                        end else if (sel_be[1:0] != 2'b00) begin
                            state <= PH1;
                            ctl   <= phase_bus(1'b1, sel_we, sel_be, sel_wa, core.d_wdata);
                        end else begin
                            state        <= DONE;
                            core.d_ready <= 1'b1;
                        end
                    end
                end
                PH0: begin
                    if (!lat_we) begin
                        if (gnt_d) core.d_rdata[31:16] <= sram_dq;
                        else       core.i_rdata[31:16] <= sram_dq;
                    end
                    if (!lat_we || lat_be[1:0] != 2'b00) begin
                        state <= PH1;
                        ctl   <= phase_bus(1'b1, lat_we, lat_be, lat_wa, lat_wd);
                    end else begin
                        state        <= DONE;
                        ctl          <= BUS_IDLE;
                        core.d_ready <= gnt_d;
                        core.i_ready <= ~gnt_d;
                    end
                end
                PH1: begin
                    if (!lat_we) begin
                        if (gnt_d) core.d_rdata[15:0] <= sram_dq;
                        else       core.i_rdata[15:0] <= sram_dq;
                    end
                    state        <= DONE;
                    ctl          <= BUS_IDLE;
                    core.d_ready <= gnt_d;
                    core.i_ready <= ~gnt_d;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ctl   <= BUS_IDLE;
                end
            endcase
        end
    end

    assign sram_a    = ctl.a;
    assign sram_ce_n = ctl.ce_n;
    assign sram_we_n = ctl.we_n;
    assign sram_oe_n = ctl.oe_n;
    assign sram_ub_n = ctl.ub_n;
    assign sram_lb_n = ctl.lb_n;
    // Drive only in write phases, so the bus is never driven while oe_n is low.
    assign sram_dq   = ctl.we_n ? 16'hzzzz : ctl.dq;
endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: behavioural SRAM, scoreboard of expected ready/rdata, table of word accesses
// plus hand sequences for reset, bus timing, contention and reset during a write.
module tb_sram_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_ctrl_if core();
    wire  [15:0] sram_dq;
    logic [19:0] sram_a;
    logic        sram_we_n, sram_ce_n, sram_oe_n, sram_lb_n, sram_ub_n;

    sram_ctrl dut (
        .clk(clk), .rst_n(rst_n), .core(core),
        .sram_a(sram_a), .sram_dq(sram_dq), .sram_we_n(sram_we_n), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
    );

    // Behavioural SRAM
    logic [15:0] mem [0:1023];
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_a[9:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) mem[sram_a[9:0]][7:0]  <= sram_dq[7:0];
            if (!sram_ub_n) mem[sram_a[9:0]][15:8] <= sram_dq[15:8];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          port;   // 1 = load/store, 0 = fetch
        logic [31:0] rdata;
        int          start;
        int          lat;    // 0 = latency not checked
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct packed {
        logic [19:0] a;
        logic [15:0] dq;
        logic        we_n;
        logic        oe_n;
        logic        ub_n;
        logic        lb_n;
    } ph_t;
    ph_t plog[$];
    int  act_cnt = 0;

    // Scoreboard: pop on every ready pulse
    always @(negedge clk) begin
        if (rst_n && (core.i_ready || core.d_ready)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got i=%0b d=%0b expected none", core.i_ready, core.d_ready);
            end else begin
                mon_e = sb.pop_front();
                check("ready_port", {core.i_ready, core.d_ready}, mon_e.port ? 32'd1 : 32'd2);
                check("rdata", mon_e.port ? core.d_rdata : core.i_rdata, mon_e.rdata);
                if (mon_e.lat != 0) check("latency", cyc - mon_e.start, mon_e.lat);
            end
        end
    end

    // Bus log and idle/contention-free bus rules
    always @(negedge clk) begin
        if (!sram_ce_n) begin
            act_cnt++;
            plog.push_back('{sram_a, sram_dq, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n});
        end else begin
            check("idle_ctl", {sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}, 4'hF);
            check("idle_a", sram_a, 0);
            check("idle_dq_z", sram_dq === 16'hzzzz, 1);
        end
        if (!sram_we_n) check("we_oe_excl", sram_oe_n, 1);
    end

    task automatic access(input bit port, input bit we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp, input int lat, input int ncyc);
        int  n0;
        bit  done;
        @(posedge clk); #1;
        plog.delete();
        n0 = act_cnt;
        if (port) begin
            core.d_req = 1'b1; core.d_we = we; core.d_be = be; core.d_addr = addr; core.d_wdata = wdata;
        end else begin
            core.i_req = 1'b1; core.i_addr = addr;
        end
        sb.push_back('{port, exp, cyc, lat});
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (port ? core.d_ready : core.i_ready) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no ready expected ready within 20 cycles (addr %h)", addr);
            sb.delete();
        end
        @(posedge clk); #1;
        core.i_req = 1'b0;
        core.d_req = 1'b0;
        check("sram_cycles", act_cnt - n0, ncyc);
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
        int          ncyc;
    } vec_t;
    vec_t vt[14];

    initial begin
        int seen;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        core.i_req = 0; core.i_addr = 0;
        core.d_req = 0; core.d_we = 0; core.d_be = 0; core.d_addr = 0; core.d_wdata = 0;

        vt[0]  = '{1, 0, 4'b0000, 32'h0000_0040, 32'h0,          32'hDEADBEEF, 3, 2};
        vt[1]  = '{0, 0, 4'b0000, 32'h0000_0040, 32'h0,          32'hDEADBEEF, 3, 2};
        vt[2]  = '{1, 1, 4'b0010, 32'h0000_0040, 32'h0000AA00,   32'hDEADBEEF, 2, 1};
        vt[3]  = '{1, 0, 4'b0000, 32'h0000_0040, 32'h0,          32'hDEADAAEF, 3, 2};
        vt[4]  = '{1, 1, 4'b0000, 32'h0000_0040, 32'hFFFFFFFF,   32'hDEADAAEF, 1, 0};
        vt[5]  = '{1, 0, 4'b0000, 32'h0000_0040, 32'h0,          32'hDEADAAEF, 3, 2};
        vt[6]  = '{1, 1, 4'b1100, 32'h0000_0044, 32'h12345678,   32'hDEADAAEF, 2, 1};
        vt[7]  = '{1, 0, 4'b0000, 32'h0000_0044, 32'h0,          32'h12340000, 3, 2};
        vt[8]  = '{1, 1, 4'b0001, 32'h0000_0047, 32'h0000009A,   32'h12340000, 2, 1};
        vt[9]  = '{1, 0, 4'b0000, 32'hFFE0_0044, 32'h0,          32'h1234009A, 3, 2};
        vt[10] = '{1, 1, 4'b1001, 32'h0000_0048, 32'hA1B2C3D4,   32'h1234009A, 3, 2};
        vt[11] = '{1, 0, 4'b0000, 32'h0000_0048, 32'h0,          32'hA10000D4, 3, 2};
        vt[12] = '{0, 0, 4'b0000, 32'h0000_0050, 32'h0,          32'hCAFEF00D, 3, 2};
        vt[13] = '{0, 0, 4'b0000, 32'h0000_0049, 32'h0,          32'hA10000D4, 3, 2};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ctl", {sram_we_n, sram_ce_n, sram_oe_n, sram_lb_n, sram_ub_n}, 5'h1F);
        check("rst_a", sram_a, 0);
        check("rst_dq_z", sram_dq === 16'hzzzz, 1);
        check("rst_ready", {core.i_ready, core.d_ready}, 0);
        check("rst_i_rdata", core.i_rdata, 0);
        check("rst_d_rdata", core.d_rdata, 0);

        // Full word store, phase by phase
        access(1, 1, 4'b1111, 32'h40, 32'hDEADBEEF, 32'h0, 3, 2);
        if (plog.size() == 2) begin
            check("st_ph0_a", plog[0].a, 20'h00020);
            check("st_ph0_dq", plog[0].dq, 16'hDEAD);
            check("st_ph0_ctl", {plog[0].we_n, plog[0].oe_n, plog[0].ub_n, plog[0].lb_n}, 4'b0100);
            check("st_ph1_a", plog[1].a, 20'h00021);
            check("st_ph1_dq", plog[1].dq, 16'hBEEF);
        end
        access(1, 1, 4'b1111, 32'h50, 32'hCAFEF00D, 32'h0, 3, 2);

        // Contention straight out of reset: D, I, D, I
        @(posedge clk); #1;
        rst_n = 1'b0;
        core.i_req = 1'b1; core.i_addr = 32'h40;
        core.d_req = 1'b1; core.d_we = 1'b0; core.d_addr = 32'h50;
        sb.push_back('{1, 32'hCAFEF00D, 0, 0});
        sb.push_back('{0, 32'hDEADBEEF, 0, 0});
        sb.push_back('{1, 32'hCAFEF00D, 0, 0});
        sb.push_back('{0, 32'hDEADBEEF, 0, 0});
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 60 && seen < 4; k++) begin
            @(negedge clk);
            if (core.i_ready || core.d_ready) seen++;
        end
        check("cont_grants", seen, 4);
        @(posedge clk); #1;
        core.i_req = 1'b0;
        core.d_req = 1'b0;
        check("cont_sb_empty", sb.size(), 0);
        sb.delete();

        // Table of accesses
        for (int i = 0; i < 14; i++) begin
            access(vt[i].port, vt[i].we, vt[i].be, vt[i].addr, vt[i].wdata, vt[i].exp, vt[i].lat, vt[i].ncyc);
            if (i == 0 && plog.size() > 0)
                check("ld_ph0_ctl", {plog[0].a, plog[0].we_n, plog[0].oe_n}, {20'h00020, 2'b10});
            if (i == 2 && plog.size() > 0) begin
                check("byte_a", plog[0].a, 20'h00021);
                check("byte_ctl", {plog[0].we_n, plog[0].ub_n, plog[0].lb_n}, 3'b001);
                check("byte_dq", plog[0].dq[15:8], 8'hAA);
            end
        end

        // Reset dropped during PH0 of a store
        @(posedge clk); #1;
        core.d_req = 1'b1; core.d_we = 1'b1; core.d_be = 4'hF;
        core.d_addr = 32'h80; core.d_wdata = 32'h11112222;
        @(negedge clk);
        @(negedge clk);
        check("midw_ph0", {sram_ce_n, sram_we_n}, 2'b00);
        rst_n = 1'b0;
        #1;
        check("midw_ctl", {sram_we_n, sram_ce_n, sram_oe_n, sram_lb_n, sram_ub_n}, 5'h1F);
        check("midw_dq_z", sram_dq === 16'hzzzz, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midw_no_ready", core.d_ready, 0);
        end
        core.d_req = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        access(1, 0, 4'b0000, 32'h80, 32'h0, 32'h00000000, 3, 2);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
